// File: rtl/plru_pkg.sv
// plru_pkg: shared sizing, types and FSM encoding for the tree-PLRU controller.
// Optional feature macro used by the controller: PLRU_FORWARD_EN.
package plru_pkg;

    localparam int WAYS     = 4;
    localparam int SET_BITS = 6;
    localparam int WAY_BITS = $clog2(WAYS);

    typedef logic [WAY_BITS-1:0] way_t;
    typedef logic [SET_BITS-1:0] set_t;
    typedef logic [WAYS-2:0]     plru_state_t;

    // Controller FSM: normal request service, or the all-sets clearing sweep.
    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } fsm_t;

endpackage

// File: rtl/plru_tree.sv
// plru_tree: purely combinational tree-PLRU logic for one set.
// Node bit 0 is the root, node i has children 2i+1 / 2i+2, and a 0 bit
// steers the victim search to the left child. The touch walks the path to
// the touched way and flips each node on it to point away from that way.
module plru_tree #(
    parameter  int WAYS = 4,
    localparam int WB   = $clog2(WAYS)
) (
    input  logic [WAYS-2:0] i_state,
    input  logic            i_hit,
    input  logic [WB-1:0]   i_hit_way,
    output logic [WB-1:0]   o_victim,
    output logic [WAYS-2:0] o_next_state
);

    logic [WB-1:0] w_touch;

    // A hit refreshes the hit way; a miss refreshes the way it allocates.
    assign w_touch = i_hit ? i_hit_way : o_victim;

    // Walk from the root to a leaf following the node bits, MSB of way first.
    always_comb begin : victim_walk
        int              node;
        logic [WAYS-2:0] w_sh;
        node     = 0;
        w_sh     = '0;
        o_victim = '0;
        for (int l = 0; l < WB; l++) begin
            w_sh              = i_state >> node;
            o_victim[WB-1-l]  = w_sh[0];
            node              = 2 * node + 1 + int'(w_sh[0]);
        end
    end

    // Walk the touched way's path, setting each node to point the other way.
    always_comb begin : touch_walk
        int              node;
        logic            w_dir;
        logic [WAYS-2:0] w_mask;
        node         = 0;
        w_dir        = 1'b0;
        w_mask       = '0;
        o_next_state = i_state;
        for (int l = 0; l < WB; l++) begin
            w_dir     = w_touch[WB-1-l];
            w_mask    = '0;
            w_mask[0] = 1'b1;
            w_mask    = w_mask << node;
            if (w_dir) begin
                o_next_state = o_next_state & ~w_mask;
            end else begin
                o_next_state = o_next_state | w_mask;
            end
            node = 2 * node + 1 + int'(w_dir);
        end
    end

endmodule

// File: rtl/plru_controller.sv
// plru_controller: tree-PLRU replacement controller in front of a
// flip-flop state RAM with combinational read.
// Build option: define PLRU_FORWARD_EN to forward the in-flight write-back
// to a same-set request; without it such a request stalls for one cycle.
//
// Handshake: a request is taken in any cycle where req_valid && req_ready;
// req_ready never depends on req_valid. The response (victim_valid pulse,
// victim_way) and the state write-back both appear exactly one cycle later.
module plru_controller
    import plru_pkg::fsm_t;
#(
    parameter  int WAYS     = plru_pkg::WAYS,
    parameter  int SET_BITS = plru_pkg::SET_BITS,
    localparam int WAY_BITS = $clog2(WAYS)
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [SET_BITS-1:0] req_set,
    input  logic                req_hit,
    input  logic [WAY_BITS-1:0] req_way,
    output logic                victim_valid,
    output logic [WAY_BITS-1:0] victim_way,
    input  logic                flush,
    output logic [SET_BITS-1:0] ram_raddr,
    output logic [SET_BITS-1:0] ram_waddr,
    output logic                ram_write_en,
    output logic [WAYS-2:0]     ram_data_in,
    input  logic [WAYS-2:0]     ram_data_out,
    output fsm_t                dbg_state
);

    import plru_pkg::*;

    localparam logic [SET_BITS-1:0] LAST_SET = '1;

    fsm_t                r_state;
    logic [SET_BITS-1:0] r_cnt;
    logic                r_rdy;
    logic                r_vvalid;
    logic [WAY_BITS-1:0] r_victim;
    logic                r_wen;
    logic [SET_BITS-1:0] r_waddr;
    logic [WAYS-2:0]     r_wdata;

    logic                w_pending_same;
    logic                w_accept;
    logic [WAYS-2:0]     w_cur_state;
    logic [WAY_BITS-1:0] w_victim;
    logic [WAYS-2:0]     w_next_state;

    // The RAM is always read at the incoming set.
    assign ram_raddr = req_set;

    // A request write-back (not a sweep write) is landing on this same set now.
    assign w_pending_same = r_vvalid && (r_waddr == req_set);

`ifdef PLRU_FORWARD_EN
    // Same-set request takes the value being written instead of the stale RAM word.
    assign req_ready   = r_rdy && (r_state == IDLE) && !flush;
    assign w_cur_state = w_pending_same ? r_wdata : ram_data_out;
`else
    // Same-set request waits one cycle for the write-back to reach the RAM.
    assign req_ready   = r_rdy && (r_state == IDLE) && !flush && !w_pending_same;
    assign w_cur_state = ram_data_out;
`endif

    assign w_accept = req_valid && req_ready;

    plru_tree #(
        .WAYS (WAYS)
    ) u_tree (
        .i_state      (w_cur_state),
        .i_hit        (req_hit),
        .i_hit_way    (req_way),
        .o_victim     (w_victim),
        .o_next_state (w_next_state)
    );

    // FSM plus registered response / write port. A write-back already on the
    // port when flush rises retires in that cycle; the sweep starts next cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_rdy    <= 1'b0;
            r_vvalid <= 1'b0;
            r_victim <= '0;
            r_wen    <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
        end else begin
            r_rdy    <= 1'b1;
            r_vvalid <= 1'b0;
            r_wen    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (flush) begin
                        r_state <= FLUSH;
                        r_cnt   <= '0;
                        r_wen   <= 1'b1;
                        r_waddr <= '0;
                        r_wdata <= '0;
                    end else if (w_accept) begin
                        r_vvalid <= 1'b1;
                        r_victim <= w_victim;
                        r_wen    <= 1'b1;
                        r_waddr  <= req_set;
                        r_wdata  <= w_next_state;
                    end
                end
                FLUSH: begin
                    // flush is deliberately not looked at while sweeping
                    if (r_cnt == LAST_SET) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_wen   <= 1'b1;
                        r_waddr <= r_cnt + 1'b1;
                        r_wdata <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign victim_valid = r_vvalid;
    assign victim_way   = r_victim;
    assign ram_write_en = r_wen;
    assign ram_waddr    = r_waddr;
    assign ram_data_in  = r_wdata;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_plru_controller.sv
// tb_plru_controller: randomized bench for plru_controller (WAYS=4, SET_BITS=6)
// with a set-indexed reference of PLRU states and an expected-output queue.
module tb_plru_controller;

    import plru_pkg::*;

    logic       clk;
    logic       resetn;
    logic       req_valid;
    logic       req_ready;
    logic [5:0] req_set;
    logic       req_hit;
    logic [1:0] req_way;
    logic       victim_valid;
    logic [1:0] victim_way;
    logic       flush;
    logic [5:0] ram_raddr;
    logic [5:0] ram_waddr;
    logic       ram_write_en;
    logic [2:0] ram_data_in;
    logic [2:0] ram_data_out;
    fsm_t       dbg_state;

    plru_controller #(
        .WAYS     (4),
        .SET_BITS (6)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_set      (req_set),
        .req_hit      (req_hit),
        .req_way      (req_way),
        .victim_valid (victim_valid),
        .victim_way   (victim_way),
        .flush        (flush),
        .ram_raddr    (ram_raddr),
        .ram_waddr    (ram_waddr),
        .ram_write_en (ram_write_en),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / reset / state RAM ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] mem [64];
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 3'b000;
    end
    always @(posedge clk) begin
        if (ram_write_en) mem[ram_waddr] <= ram_data_in;
    end
    assign ram_data_out = mem[ram_raddr];

    // ---------------- scoreboard ----------------
    int          n_vec;
    int          n_err;
    logic [12:0] exp_q[$];    // {vv, vw[1:0], wen, waddr[5:0], wdata[2:0]}
    logic [2:0]  ref_st [64]; // logical PLRU state of every set
    logic [12:0] m_cur_e;     // expected outputs of the current cycle
    logic        m_rdy;
    logic        m_flush;
    int          m_cnt;
    logic        last_ready;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Victim by interval halving: a 1 bit keeps the upper half of the ways.
    function automatic logic [1:0] ref_victim(input logic [2:0] st);
        int lo, hi, node, mid;
        lo = 0; hi = 4; node = 0;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (((st >> node) & 3'b001) != 3'b000) begin
                lo = mid; node = 2 * node + 2;
            end else begin
                hi = mid; node = 2 * node + 1;
            end
        end
        return 2'(lo);
    endfunction

    // Touch: every node above the way is aimed at the half not holding it.
    function automatic logic [2:0] ref_touch(input logic [2:0] st, input int way);
        int lo, hi, node, mid;
        logic [2:0] r;
        lo = 0; hi = 4; node = 0; r = st;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (way < mid) begin
                r = r | (3'b001 << node);
                hi = mid; node = 2 * node + 1;
            end else begin
                r = r & ~(3'b001 << node);
                lo = mid; node = 2 * node + 2;
            end
        end
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    // Entered 1 time unit after a rising edge; returns at the same phase of the next cycle.
    task automatic step(input logic v, input logic [5:0] s, input logic h,
                        input logic [1:0] w, input logic f);
        logic        exp_rdy;
        logic        acc;
        logic        fw;
        logic [5:0]  fa;
        logic [12:0] e;
        logic [2:0]  cur;
        logic [2:0]  ns;
        logic [1:0]  vic;
        req_valid = v; req_set = s; req_hit = h; req_way = w; flush = f;
        #1;
        exp_rdy = m_rdy && !m_flush && !f;
`ifndef PLRU_FORWARD_EN
        if (m_cur_e[12] && (m_cur_e[8:3] == s)) exp_rdy = 1'b0;
`endif
        check("req_ready", req_ready, exp_rdy);
        last_ready = req_ready;
        acc = v && exp_rdy;
        e = '0;
        if (m_flush) begin
            if (m_cnt == 63) begin
                m_flush = 1'b0;
                m_cnt   = 0;
            end else begin
                m_cnt = m_cnt + 1;
                e = {1'b0, 2'b00, 1'b1, 6'(m_cnt), 3'b000};
            end
        end else if (f) begin
            m_flush = 1'b1;
            m_cnt   = 0;
            e = {1'b0, 2'b00, 1'b1, 6'd0, 3'b000};
        end else if (acc) begin
            cur = ref_st[s];
            vic = ref_victim(cur);
            ns  = ref_touch(cur, h ? int'(w) : int'(vic));
            ref_st[s] = ns;
            e = {1'b1, vic, 1'b1, s, ns};
        end
        exp_q.push_back(e);
        fw = m_cur_e[9] && !m_cur_e[12];
        fa = m_cur_e[8:3];
        @(posedge clk);
        if (fw) ref_st[fa] = 3'b000;
        #1;
        e = exp_q.pop_front();
        m_cur_e = e;
        check("victim_valid", victim_valid, e[12]);
        if (e[12]) check("victim_way", victim_way, e[11:10]);
        check("ram_write_en", ram_write_en, e[9]);
        if (e[9]) begin
            check("ram_waddr", ram_waddr, e[8:3]);
            check("ram_data_in", ram_data_in, e[2:0]);
        end
        check("fsm_state", dbg_state, m_flush);
    endtask

    task automatic do_reset();
        req_valid = 1'b0; flush = 1'b0; req_hit = 1'b0;
        resetn = 1'b0;
        #1;
        check("rst_victim_valid", victim_valid, 0);
        check("rst_victim_way", victim_way, 0);
        check("rst_ram_write_en", ram_write_en, 0);
        check("rst_ram_waddr", ram_waddr, 0);
        check("rst_ram_data_in", ram_data_in, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_state", dbg_state, IDLE);
        m_rdy = 1'b0; m_flush = 1'b0; m_cnt = 0; m_cur_e = '0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_ready", req_ready, 0);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        m_rdy = 1'b1;
        check("post_rst_ready", req_ready, 1);
        check("post_rst_state", dbg_state, IDLE);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int         nr;
        int         nw;
        logic       done;
        logic [5:0] s;
        logic [5:0] last_s;
        n_vec = 0; n_err = 0;
        resetn = 1'b0; req_valid = 1'b0; req_set = '0; req_hit = 1'b0;
        req_way = '0; flush = 1'b0;
        for (int i = 0; i < 64; i++) ref_st[i] = 3'b000;
        m_cur_e = '0; last_ready = 1'b0;
        #2;
        do_reset();

        // Fresh miss, then a back-to-back miss to the same set.
        step(1'b1, 6'd5, 1'b0, 2'd0, 1'b0);
        check("miss1_way", victim_way, 0);
        check("miss1_waddr", ram_waddr, 5);
        check("miss1_data", ram_data_in, 3'b011);
        step(1'b1, 6'd5, 1'b0, 2'd0, 1'b0);
`ifndef PLRU_FORWARD_EN
        check("miss2_stall", victim_valid, 0);
        step(1'b1, 6'd5, 1'b0, 2'd0, 1'b0);
`endif
        check("miss2_way", victim_way, 2);
        check("miss2_data", ram_data_in, 3'b110);

        // Hit on way 3 of an untouched set.
        step(1'b1, 6'd9, 1'b1, 2'd3, 1'b0);
        check("hit3_valid", victim_valid, 1);
        check("hit3_way", victim_way, 0);
        step(1'b0, 6'd0, 1'b0, 2'd0, 1'b0);

        // Randomized traffic, concentrated on a few sets, with rare flushes.
        last_s = 6'd5;
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0: s = 6'd5;
                1: s = 6'd9;
                2: s = last_s;
                default: s = 6'($urandom_range(0, 63));
            endcase
            last_s = s;
            step($urandom_range(0, 3) != 0, s, 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), $urandom_range(0, 149) == 0);
        end

        // Let any sweep finish, then a full flush with a stray flush mid-sweep.
        for (int i = 0; i < 80; i++) step(1'b0, 6'd0, 1'b0, 2'd0, 1'b0);
        step(1'b1, 6'd7, 1'b0, 2'd0, 1'b0);
        step(1'b0, 6'd0, 1'b0, 2'd0, 1'b1);
        nr = last_ready ? 0 : 1;
        nw = 0;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (ram_write_en) nw++;
            step(1'b1, 6'($urandom_range(10, 63)), 1'b0, 2'd0, i == 10);
            if (!last_ready) nr++;
            else done = 1'b1;
        end
        check("flush_done", done, 1);
        check("flush_ready_low", nr, 65);
        check("flush_writes", nw, 64);
        step(1'b1, 6'd5, 1'b0, 2'd0, 1'b0);
        check("post_flush_way", victim_way, 0);
        check("post_flush_data", ram_data_in, 3'b011);

        // Reset in the middle of a sweep.
        step(1'b0, 6'd0, 1'b0, 2'd0, 1'b1);
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            if (ram_write_en && ram_waddr == 6'd20) done = 1'b1;
            else step(1'b0, 6'd0, 1'b0, 2'd0, 1'b0);
        end
        check("sweep_reached_20", done, 1);
        do_reset();

        // More traffic after the aborted sweep.
        for (int i = 0; i < 200; i++) begin
            step($urandom_range(0, 3) != 0, 6'($urandom_range(15, 25)),
                 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation did not finish");
    end

endmodule
